// File: rtl/alu_execute_stage_if.sv
// Pipeline-boundary interfaces around the execute stage: decode->execute
// carries the decoded instruction, execute->memory carries the ALU result.
interface decode_execute_if #(parameter int N = 32);
  logic         valid;
  logic         ready;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [N-1:0] reg_A;
  logic [N-1:0] reg_B;
  logic [N-1:0] imm_extended;

  modport master (output valid, opcode, funct3, funct7, reg_A, reg_B, imm_extended,
                  input  ready);
  modport slave  (input  valid, opcode, funct3, funct7, reg_A, reg_B, imm_extended,
                  output ready);
endinterface

interface execute_memory_if #(parameter int N = 32);
  logic         valid;
  logic         ready;
  logic [N-1:0] alu_result;
  logic         branch_taken;

  modport master (output valid, alu_result, branch_taken, input ready);
  modport slave  (input  valid, alu_result, branch_taken, output ready);
endinterface

// File: rtl/alu_execute_stage.sv
// RV32I execute stage: integer ALU, load/store address adder and branch
// comparator, with the result registered toward the memory stage.
module alu_execute_stage #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_execute_if.slave   i_de,
  execute_memory_if.master  o_em
);

  localparam logic [6:0] OP_REG_REG = 7'b0110011;
  localparam logic [6:0] OP_REG_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  logic [N-1:0] w_a_op;
  logic [N-1:0] w_b_op;
  logic [N-1:0] w_sum;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_alu_out;
  logic [N-1:0] w_result;
  logic [4:0]   w_shamt;
  logic         w_is_sub;
  logic         w_lt_s;
  logic         w_lt_u;
  logic         w_eq;
  logic         w_taken;
  logic         w_accept;

  logic [N-1:0] r_alu_result;
  logic         r_em_valid;
  logic         r_branch_taken;

  assign w_a_op = i_de.reg_A;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_b_op = i_de.imm_extended;
    if (i_de.opcode == OP_REG_REG || i_de.opcode == OP_BRANCH)
      w_b_op = i_de.reg_B;
  end

  assign w_sum    = w_a_op + w_b_op;
  assign w_diff   = w_a_op - w_b_op;
  assign w_shamt  = w_b_op[4:0];
  assign w_lt_s   = $signed(w_a_op) < $signed(w_b_op);
  assign w_lt_u   = w_a_op < w_b_op;
  assign w_eq     = w_a_op == w_b_op;
  // Only the register form can subtract; ADDI reuses funct7 bits as immediate.
  assign w_is_sub = (i_de.opcode == OP_REG_REG) && (i_de.funct7 == F7_SUB);

  always_comb begin
    w_alu_out = '0;
    case (i_de.funct3)
      3'b000: w_alu_out = w_is_sub ? w_diff : w_sum;
      3'b001: w_alu_out = w_a_op << w_shamt;
      3'b010: w_alu_out = {{(N-1){1'b0}}, w_lt_s};
      3'b011: w_alu_out = {{(N-1){1'b0}}, w_lt_u};
      3'b100: w_alu_out = w_a_op ^ w_b_op;
      3'b101: w_alu_out = i_de.funct7[5] ? N'($signed(w_a_op) >>> w_shamt)
                                         : (w_a_op >> w_shamt);
      3'b110: w_alu_out = w_a_op | w_b_op;
      3'b111: w_alu_out = w_a_op & w_b_op;
      default: w_alu_out = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    if (i_de.opcode == OP_BRANCH) begin
      case (i_de.funct3)
        3'b000:  w_taken = w_eq;
        3'b001:  w_taken = !w_eq;
        3'b100:  w_taken = w_lt_s;
        3'b101:  w_taken = !w_lt_s;
        3'b110:  w_taken = w_lt_u;
        3'b111:  w_taken = !w_lt_u;
        default: w_taken = 1'b0;
      endcase
    end
  end

  // Branches and unknown opcodes write zero; loads/stores use the address sum.
  always_comb begin
    w_result = '0;
    case (i_de.opcode)
      OP_REG_REG, OP_REG_IMM: w_result = w_alu_out;
      OP_LOAD, OP_STORE:      w_result = w_sum;
      default:                w_result = '0;
    endcase
  end

  assign w_accept    = i_de.valid && o_em.ready;
  assign i_de.ready  = o_em.ready;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only these three control/data registers need reset; there is no storage array here.
      r_alu_result   <= '0;
      r_em_valid     <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      r_em_valid <= w_accept;
      if (w_accept) begin
        r_alu_result   <= w_result;
        r_branch_taken <= w_taken;
      end
    end
  end

  assign o_em.valid        = r_em_valid;
  assign o_em.alu_result   = r_alu_result;
  assign o_em.branch_taken = r_branch_taken;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed-vector bench for alu_execute_stage: hand-computed results,
// backpressure hold and asynchronous reset behaviour.
module tb_alu_execute_stage;

  localparam logic [6:0] RR = 7'b0110011;
  localparam logic [6:0] RI = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  decode_execute_if #(.N(32)) de_if ();
  execute_memory_if #(.N(32)) em_if ();

  alu_execute_stage #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_de  (de_if.slave),
    .o_em  (em_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; presents one op, then checks it one edge later.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] exp_res,
                        input logic exp_br);
    de_if.opcode       = opc;
    de_if.funct3       = f3;
    de_if.funct7       = f7;
    de_if.reg_A        = a;
    de_if.reg_B        = b;
    de_if.imm_extended = imm;
    de_if.valid        = 1'b1;
    @(posedge clk);
    #1;
    de_if.valid = 1'b0;
    check({tag, ".result"}, em_if.alu_result, exp_res);
    check({tag, ".valid"},  {31'd0, em_if.valid}, 32'd1);
    check({tag, ".taken"},  {31'd0, em_if.branch_taken}, {31'd0, exp_br});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    de_if.valid = 1'b0;
    de_if.opcode = '0;
    de_if.funct3 = '0;
    de_if.funct7 = '0;
    de_if.reg_A = '0;
    de_if.reg_B = '0;
    de_if.imm_extended = '0;
    em_if.ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset.result", em_if.alu_result, 32'd0);
    check("reset.valid",  {31'd0, em_if.valid}, 32'd0);
    check("reset.taken",  {31'd0, em_if.branch_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add",   RR, 3'b000, 7'h00, 32'd5, 32'd3, 32'd0, 32'd8, 1'b0);
    run_op("sub",   RR, 3'b000, 7'h20, 32'd8, 32'd3, 32'd0, 32'd5, 1'b0);
    run_op("or",    RR, 3'b110, 7'h00, 32'hA, 32'h5, 32'd0, 32'hF, 1'b0);
    run_op("and",   RR, 3'b111, 7'h00, 32'hA, 32'h5, 32'd0, 32'h0, 1'b0);
    run_op("xor",   RR, 3'b100, 7'h00, 32'hA, 32'h5, 32'd0, 32'hF, 1'b0);
    run_op("slt_a", RR, 3'b010, 7'h00, 32'hFFFFFFF5, 32'd5, 32'd0, 32'd1, 1'b0);
    run_op("slt_b", RR, 3'b010, 7'h00, 32'd5, 32'hFFFFFFF5, 32'd0, 32'd0, 1'b0);
    run_op("sltu_a", RR, 3'b011, 7'h00, 32'd3, 32'd5, 32'd0, 32'd1, 1'b0);
    run_op("sltu_b", RR, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    run_op("sra_rr", RR, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 1'b0);
    run_op("sll_shamt", RR, 3'b001, 7'h00, 32'h1111, 32'h22, 32'd0, 32'h4444, 1'b0);

    // funct7=0x20 on ADDI must still add.
    run_op("addi",  RI, 3'b000, 7'h20, 32'd0, 32'd99, 32'd5, 32'd5, 1'b0);
    run_op("ori",   RI, 3'b110, 7'h00, 32'h1010, 32'd0, 32'h101,  32'h1111, 1'b0);
    run_op("andi",  RI, 3'b111, 7'h00, 32'h1010, 32'd0, 32'h1000, 32'h1000, 1'b0);
    run_op("xori",  RI, 3'b100, 7'h00, 32'h1010, 32'd0, 32'h110,  32'h1100, 1'b0);
    run_op("slli",  RI, 3'b001, 7'h00, 32'h1111, 32'd0, 32'd2, 32'h4444, 1'b0);
    run_op("srli",  RI, 3'b101, 7'h00, 32'h1111, 32'd0, 32'd2, 32'h444, 1'b0);
    run_op("srli_neg", RI, 3'b101, 7'h00, 32'hFFFFFFF0, 32'd0, 32'd2, 32'h3FFFFFFC, 1'b0);
    run_op("srai",  RI, 3'b101, 7'h20, 32'hFFFFFFF0, 32'd0, 32'h402, 32'hFFFFFFFC, 1'b0);

    run_op("wrap_add", RR, 3'b000, 7'h00, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h80000000, 1'b0);
    run_op("wrap_sub", RR, 3'b000, 7'h20, 32'h80000000, 32'd1, 32'd0, 32'h7FFFFFFF, 1'b0);
    run_op("and_zero", RR, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b0);

    run_op("load",  LD, 3'b010, 7'h20, 32'h1000, 32'd7, 32'h10, 32'h1010, 1'b0);
    run_op("store", ST, 3'b010, 7'h00, 32'h2000, 32'd7, 32'hFFFFFFF0, 32'h1FF0, 1'b0);

    run_op("beq_t",  BR, 3'b000, 7'h00, 32'd7, 32'd7, 32'd0, 32'd0, 1'b1);
    run_op("blt_f",  BR, 3'b100, 7'h00, 32'd5, 32'hFFFFFFF5, 32'd0, 32'd0, 1'b0);
    run_op("bne_f",  BR, 3'b001, 7'h00, 32'd7, 32'd7, 32'd0, 32'd0, 1'b0);
    run_op("bge_t",  BR, 3'b101, 7'h00, 32'd5, 32'hFFFFFFF5, 32'd0, 32'd0, 1'b1);
    run_op("bltu_t", BR, 3'b110, 7'h00, 32'd5, 32'hFFFFFFF5, 32'd0, 32'd0, 1'b1);
    run_op("bgeu_f", BR, 3'b111, 7'h00, 32'd5, 32'hFFFFFFF5, 32'd0, 32'd0, 1'b0);
    run_op("br_f3_010", BR, 3'b010, 7'h00, 32'd7, 32'd7, 32'd0, 32'd0, 1'b0);
    run_op("beq_t2", BR, 3'b000, 7'h00, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1);

    // Backpressure: branch_taken=1 and result=0 must hold.
    de_if.opcode = RR; de_if.funct3 = 3'b000; de_if.funct7 = 7'h00;
    de_if.reg_A = 32'd1; de_if.reg_B = 32'd2;
    de_if.valid = 1'b1;
    em_if.ready = 1'b0;
    #1;
    check("hold.de_ready", {31'd0, de_if.ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("hold.result", em_if.alu_result, 32'd0);
      check("hold.valid",  {31'd0, em_if.valid}, 32'd0);
      check("hold.taken",  {31'd0, em_if.branch_taken}, 32'd1);
    end
    de_if.valid = 1'b0;
    em_if.ready = 1'b1;
    #1;
    check("idle.de_ready", {31'd0, de_if.ready}, 32'd1);

    run_op("nonbr_clears", RR, 3'b000, 7'h00, 32'd5, 32'd3, 32'd0, 32'd8, 1'b0);
    run_op("unknown_op", LUI, 3'b000, 7'h00, 32'd5, 32'd3, 32'h1234, 32'd0, 1'b0);
    run_op("wrap_sub2", RR, 3'b000, 7'h20, 32'h80000000, 32'd1, 32'd0, 32'h7FFFFFFF, 1'b0);

    // Idle cycle: valid drops, result holds.
    @(posedge clk);
    #1;
    check("idle.valid",  {31'd0, em_if.valid}, 32'd0);
    check("idle.result", em_if.alu_result, 32'h7FFFFFFF);

    // Re-establish a valid output, then reset with another op in flight.
    de_if.opcode = RR; de_if.funct3 = 3'b000; de_if.funct7 = 7'h00;
    de_if.reg_A = 32'd5; de_if.reg_B = 32'd3;
    de_if.valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.result", em_if.alu_result, 32'd0);
    check("rst_mid.valid",  {31'd0, em_if.valid}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.result", em_if.alu_result, 32'd0);
    check("rst_hold.valid",  {31'd0, em_if.valid}, 32'd0);
    @(negedge clk);
    de_if.valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.valid", {31'd0, em_if.valid}, 32'd0);
    run_op("post_rst.add", RR, 3'b000, 7'h00, 32'd5, 32'd3, 32'd0, 32'd8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
